// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the RISC-V pipeline: data
//               width, canonical NOP encoding and the fetch skid FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 : the canonical bubble instruction
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // RUN  : IF/ID is fed straight from the memory read port
  // HOLD : the memory result was parked in the skid register during a stall
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry skid register for the fetch stage. On the first
//               stalled edge it captures the instruction returning from the
//               synchronous memory; while held, the memory port returns data
//               for the next address and must be ignored. The output mux
//               selects the source for the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] skid_q;

  // FSM and skid capture: park the in-flight result on entry to a stall,
  // drop it on flush, return to direct feed on release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      skid_q  <= NOP_INSTR;
    end else if (flush_i) begin
      state_q <= RUN;
      skid_q  <= NOP_INSTR;
    end else if (stall_i) begin
      if (state_q == RUN) begin
        state_q <= HOLD;
        skid_q  <= imem_rdata_i;
      end
    end else begin
      state_q <= RUN;
    end
  end

  // Once held, the memory port returns mem[pc_F], not the parked instruction.
  assign instr_o = (state_q == HOLD) ? skid_q : imem_rdata_i;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, drives a synchronous
//               (1-cycle latency) instruction memory and holds the IF/ID
//               pipeline register. Holds on stall_IFID, squashes and
//               redirects on flush. Optional performance counters are built
//               when the FETCH_PERF_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall_IFID,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_instr_count,
  output logic [31:0] perf_stall_count,
  output logic [31:0] perf_flush_count
`endif
);

  // Word alignment is forced on both the reset address and branch targets.
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [XLEN-1:0] pc_F_q,      pc_F_d;
  logic [XLEN-1:0] req_pc_q,    req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] pc_ID_q,     pc_ID_d;
  logic [XLEN-1:0] instr_ID_q,  instr_ID_d;
  logic            valid_ID_q,  valid_ID_d;

  logic [XLEN-1:0] fetch_instr;
  logic            advance;
  logic            unused_tgt_bits;

  assign unused_tgt_bits = ^branch_target[1:0];
  assign advance         = !flush && !stall_IFID;

  fetch_skid_buf u_skid (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall_i      (stall_IFID),
    .flush_i      (flush),
    .imem_rdata_i (imem_rdata),
    .instr_o      (fetch_instr)
  );

  // Next-state for PC, in-flight request and IF/ID: flush beats stall beats
  // advance. Bubbles always carry NOP so stale memory data never reaches ID.
  always_comb begin
    pc_F_d      = pc_F_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    pc_ID_d     = pc_ID_q;
    instr_ID_d  = instr_ID_q;
    valid_ID_d  = valid_ID_q;
    if (flush) begin
      pc_F_d      = {branch_target[31:2], 2'b00};
      req_valid_d = 1'b0;
      pc_ID_d     = '0;
      instr_ID_d  = NOP_INSTR;
      valid_ID_d  = 1'b0;
    end else if (!stall_IFID) begin
      pc_F_d      = pc_F_q + 32'd4;
      req_pc_d    = pc_F_q;
      req_valid_d = 1'b1;
      pc_ID_d     = req_pc_q;
      instr_ID_d  = req_valid_q ? fetch_instr : NOP_INSTR;
      valid_ID_d  = req_valid_q;
    end
  end

  // PC, request tracking and IF/ID pipeline register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_F_q      <= RESET_PC_ALIGNED;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      pc_ID_q     <= '0;
      instr_ID_q  <= NOP_INSTR;
      valid_ID_q  <= 1'b0;
    end else begin
      pc_F_q      <= pc_F_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      pc_ID_q     <= pc_ID_d;
      instr_ID_q  <= instr_ID_d;
      valid_ID_q  <= valid_ID_d;
    end
  end

  assign imem_addr = pc_F_q;
  assign pc_ID     = pc_ID_q;
  assign instr_ID  = instr_ID_q;
  assign valid_ID  = valid_ID_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr_q;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running wrapping event counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (advance && req_valid_q) perf_instr_q <= perf_instr_q + 32'd1;
      if (stall_IFID && !flush)   perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)                  perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_instr_count = perf_instr_q;
  assign perf_stall_count = perf_stall_q;
  assign perf_flush_count = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Two instances share one
//               stimulus stream: dut_a (RESET_PC=0x100, mem[a]=a) and dut_b
//               (RESET_PC=0xFFFF_FFF8, mem[a]=~a) for PC wraparound.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_IFID = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;

  logic [31:0] addr_a, rdata_a = '0, pc_a, instr_a;
  logic [31:0] addr_b, rdata_b = '0, pc_b, instr_b;
  logic        valid_a, valid_b;
`ifdef FETCH_PERF_EN
  logic [31:0] pi_a, ps_a, pf_a, pi_b, ps_b, pf_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // synchronous instruction memories
  always @(posedge clock) begin
    rdata_a <= addr_a;
    rdata_b <= ~addr_b;
  end

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut_a (
    .clock(clock), .reset_n(reset_n), .stall_IFID(stall_IFID), .flush(flush),
    .branch_target(branch_target), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .pc_ID(pc_a), .instr_ID(instr_a), .valid_ID(valid_a)
`ifdef FETCH_PERF_EN
    , .perf_instr_count(pi_a), .perf_stall_count(ps_a), .perf_flush_count(pf_a)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clock(clock), .reset_n(reset_n), .stall_IFID(stall_IFID), .flush(flush),
    .branch_target(branch_target), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .pc_ID(pc_b), .instr_ID(instr_b), .valid_ID(valid_b)
`ifdef FETCH_PERF_EN
    , .perf_instr_count(pi_b), .perf_stall_count(ps_b), .perf_flush_count(pf_b)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic        chkpc;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic        chkpc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic f, input logic [31:0] t,
                     input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic cp);
    vec_t x;
    x.rst_n = r; x.stall = s; x.flush = f; x.tgt = t;
    x.ev = v; x.epc = pc; x.eins = ins; x.chkpc = cp;
    vecs.push_back(x);
  endtask

  initial begin
    exp_t e;
    // ---- vector table: inputs before the edge, expected ID after it ----
    add(0, 0, 0, 0,   0, 32'h0,   32'h13,  1); // 0  reset
    add(0, 0, 0, 0,   0, 32'h0,   32'h13,  1); // 1  reset
    add(1, 0, 0, 0,   0, 32'h0,   32'h13,  1); // 2  edge 1: bubble
    add(1, 0, 0, 0,   1, 32'h100, 32'h100, 1); // 3  edge 2
    add(1, 0, 0, 0,   1, 32'h104, 32'h104, 1); // 4
    add(1, 0, 0, 0,   1, 32'h108, 32'h108, 1); // 5
    add(1, 1, 0, 0,   1, 32'h108, 32'h108, 1); // 6  stall x3
    add(1, 1, 0, 0,   1, 32'h108, 32'h108, 1); // 7
    add(1, 1, 0, 0,   1, 32'h108, 32'h108, 1); // 8
    add(1, 0, 0, 0,   1, 32'h10C, 32'h10C, 1); // 9  release from skid
    add(1, 0, 0, 0,   1, 32'h110, 32'h110, 1); // 10
    add(1, 0, 1, 32'h202, 0, 32'h0, 32'h13, 1); // 11 flush -> 0x200
    add(1, 0, 0, 0,   0, 32'h0,   32'h13,  0); // 12 second bubble
    add(1, 0, 0, 0,   1, 32'h200, 32'h200, 1); // 13 target
    add(1, 0, 0, 0,   1, 32'h204, 32'h204, 1); // 14
    add(1, 1, 0, 0,   1, 32'h204, 32'h204, 1); // 15 stall -> HOLD (skid=0x208)
    add(1, 1, 1, 32'h300, 0, 32'h0, 32'h13, 1); // 16 flush+stall
    add(1, 0, 0, 0,   0, 32'h0,   32'h13,  0); // 17 skid must not leak
    add(1, 0, 0, 0,   1, 32'h300, 32'h300, 1); // 18
    add(1, 0, 0, 0,   1, 32'h304, 32'h304, 1); // 19
    add(1, 0, 1, 32'h400, 0, 32'h0, 32'h13, 1); // 20 flush -> 0x400
    add(1, 1, 0, 0,   0, 32'h0,   32'h13,  1); // 21 stall with no live request
    add(1, 0, 0, 0,   0, 32'h0,   32'h13,  0); // 22 bubble propagates
    add(1, 0, 0, 0,   1, 32'h400, 32'h400, 1); // 23
    add(1, 0, 0, 0,   1, 32'h404, 32'h404, 1); // 24
    add(1, 1, 0, 0,   1, 32'h404, 32'h404, 1); // 25 stall
    add(1, 1, 0, 0,   1, 32'h404, 32'h404, 1); // 26 stall in HOLD
    add(0, 1, 0, 0,   0, 32'h0,   32'h13,  1); // 27 reset mid-stall
    add(1, 0, 0, 0,   0, 32'h0,   32'h13,  1); // 28 edge 1
    add(1, 0, 0, 0,   1, 32'h100, 32'h100, 1); // 29 edge 2
    add(1, 0, 0, 0,   1, 32'h104, 32'h104, 1); // 30

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n       = vecs[i].rst_n;
      stall_IFID    = vecs[i].stall;
      flush         = vecs[i].flush;
      branch_target = vecs[i].tgt;
      e.idx = i; e.ev = vecs[i].ev; e.epc = vecs[i].epc;
      e.eins = vecs[i].eins; e.chkpc = vecs[i].chkpc;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d valid_ID", e.idx), {31'b0, valid_a}, {31'b0, e.ev});
      chk($sformatf("v%0d instr_ID", e.idx), instr_a, e.eins);
      if (e.chkpc) chk($sformatf("v%0d pc_ID", e.idx), pc_a, e.epc);
      if (i == 2) chk("edge1 imem_addr", addr_a, 32'h104);
      if (i == 0) chk("b reset valid", {31'b0, valid_b}, 32'h0);
      if (i == 3) begin
        chk("b pc0", pc_b, 32'hFFFF_FFF8);
        chk("b instr0", instr_b, ~32'hFFFF_FFF8);
      end
      if (i == 4) begin
        chk("b pc1", pc_b, 32'hFFFF_FFFC);
        chk("b instr1", instr_b, ~32'hFFFF_FFFC);
      end
      if (i == 5) begin
        chk("b pc wrap", pc_b, 32'h0000_0000);
        chk("b instr wrap", instr_b, ~32'h0000_0000);
        chk("b valid wrap", {31'b0, valid_b}, 32'h1);
      end
`ifdef FETCH_PERF_EN
      if (i == 8)  chk("perf_stall after 3", ps_a, 32'd3);
      if (i == 13) begin
        chk("perf_flush after 1", pf_a, 32'd1);
        chk("perf_instr", pi_a, 32'd6);
      end
      if (i == 27) begin
        chk("perf_instr reset", pi_a, 32'd0);
        chk("perf_stall reset", ps_a, 32'd0);
        chk("perf_flush reset", pf_a, 32'd0);
      end
`endif
    end

    // imem_addr must not follow flush/branch_target combinationally.
    flush = 1'b1;
    branch_target = 32'h0000_0500;
    #2;
    chk("imem_addr registered", addr_a, 32'h0000_010C);
    flush = 1'b0;
    @(posedge clock);
    #1;
    chk("post-probe pc_ID", pc_a, 32'h108);
    chk("post-probe imem_addr", addr_a, 32'h110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
